// File: rtl/program_loader.sv
// Boot/run controller: streams a length-prefixed program into instruction memory
// while holding the core in reset, then releases it and times the run.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start after reset
// S_HDR0  | expecting word count, low byte
// S_HDR1  | expecting word count, high byte; validates against capacity
// S_DATA  | assembling words little-endian and writing them to imem
// S_FLUSH | last word write in flight; stream closed, core still in reset
// S_RUN   | core released, counting cycles until halt or timeout
// S_DONE  | core halted normally
// S_ERR   | oversize header or run timeout
module program_loader #(
    parameter int ADDR_W     = 8,
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    input  logic              halt,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_FLUSH,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0]      CAPACITY   = 17'(2 ** ADDR_W);
    localparam logic [CNT_W-1:0] TIMEOUT    = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam bit               TIMEOUT_EN = (MAX_CYCLES != 0);

    state_t      state;
    logic [15:0] n_words;
    logic [15:0] word_cnt;
    logic [1:0]  byte_cnt;
    logic [23:0] word_buf;

    logic        xfer;
    logic [15:0] hdr_n;
    logic        hdr_over;

    always_comb begin
        xfer     = in_valid && in_ready;
        hdr_n    = {in_data, n_words[7:0]};
        hdr_over = ({1'b0, hdr_n} > CAPACITY);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            in_ready    <= 1'b0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            core_rst    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            cycle_count <= '0;
            n_words     <= '0;
            word_cnt    <= '0;
            byte_cnt    <= '0;
            word_buf    <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state       <= S_HDR0;
                        in_ready    <= 1'b1;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        error       <= 1'b0;
                        core_rst    <= 1'b1;
                        cycle_count <= '0;
                        n_words     <= '0;
                        word_cnt    <= '0;
                        byte_cnt    <= '0;
                        word_buf    <= '0;
                    end
                end

                S_HDR0: begin
                    if (xfer) begin
                        n_words[7:0] <= in_data;
                        state        <= S_HDR1;
                    end
                end

                S_HDR1: begin
                    if (xfer) begin
                        n_words[15:8] <= in_data;
                        if (hdr_n == 16'd0) begin
                            state    <= S_RUN;
                            in_ready <= 1'b0;
                            core_rst <= 1'b0;
                        end else if (hdr_over) begin
                            state    <= S_ERR;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (xfer) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        // shift right so the first byte of a word ends up in bits 7:0
                        word_buf <= {in_data, word_buf[23:8]};
                        if (byte_cnt == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_wdata <= {in_data, word_buf};
                            imem_addr  <= word_cnt[ADDR_W-1:0];
                            if (word_cnt == n_words - 16'd1) begin
                                state    <= S_FLUSH;
                                in_ready <= 1'b0;
                            end else begin
                                word_cnt <= word_cnt + 16'd1;
                            end
                        end
                    end
                end

                S_FLUSH: begin
                    state    <= S_RUN;
                    core_rst <= 1'b0;
                end

                S_RUN: begin
                    if (halt) begin
                        state    <= S_DONE;
                        core_rst <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else if (TIMEOUT_EN && (cycle_count >= TIMEOUT)) begin
                        state    <= S_ERR;
                        core_rst <= 1'b1;
                        busy     <= 1'b0;
                        error    <= 1'b1;
                    end else if (cycle_count != '1) begin
                        cycle_count <= cycle_count + CNT_ONE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: byte-stream loads with valid gaps, checked
// against a word-list model of memory writes and an outcome model of the run phase.
module tb_program_loader;

    localparam int ADDR_W = 8;
    localparam int CNT_W  = 32;
    localparam int MAXC   = 20;

    logic              clk      = 1'b0;
    logic              rst      = 1'b1;
    logic              start    = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data  = 8'h00;
    logic              halt     = 1'b0;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst;
    logic              busy;
    logic              done;
    logic              error;
    logic [CNT_W-1:0]  cycle_count;

    program_loader #(
        .ADDR_W    (ADDR_W),
        .CNT_W     (CNT_W),
        .MAX_CYCLES(MAXC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .halt       (halt),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          we_cnt   = 0;
    int          last_we_cyc = 0;
    int          fall_cyc = 0;
    logic        prev_core_rst = 1'b1;
    bit          stalled  = 1'b0;
    logic [39:0] exp_q[$];
    logic [39:0] mon_e;
    logic [31:0] prog    [0:255];
    logic [31:0] mem_obs [0:255];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    always @(posedge clk) cyc++;

    // Memory-side monitor: every write must match the next word the model expects.
    always @(negedge clk) begin
        if (imem_we) begin
            we_cnt++;
            last_we_cyc = cyc;
            mem_obs[imem_addr] = imem_wdata;
            check("we_core_held", core_rst, 1);
            if (exp_q.size() == 0) begin
                check("we_unexpected_pending", exp_q.size(), 1);
            end else begin
                mon_e = exp_q.pop_front();
                check("we_addr", imem_addr, mon_e[39:32]);
                check("we_data", imem_wdata, mon_e[31:0]);
            end
        end
        if (prev_core_rst && !core_rst) fall_cyc = cyc;
        prev_core_rst = core_rst;
    end

    task automatic send_byte(input logic [7:0] b, input int duty);
        int   waited = 0;
        logic xfer   = 1'b0;
        if (stalled) return;
        while (!xfer) begin
            @(negedge clk);
            if (int'($urandom_range(99)) < duty) begin
                in_valid = 1'b1;
                in_data  = b;
            end else begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end
            xfer = in_valid && in_ready;
            @(posedge clk);
            waited++;
            if (!xfer && waited > 400) begin
                check("byte_accept_timeout", in_ready, 1);
                stalled = 1'b1;
                return;
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("hdr0_ready", in_ready, 1);
        check("start_clears", {done, error, cycle_count}, 0);
    endtask

    task automatic load(input int n, input int duty);
        stalled = 1'b0;
        exp_q.delete();
        we_cnt = 0;
        for (int i = 0; i < n && i < 256; i++) exp_q.push_back({8'(i), prog[i]});
        send_byte(8'(n), duty);
        send_byte(8'(n >> 8), duty);
        if (n <= 256) begin
            for (int i = 0; i < n; i++)
                for (int j = 0; j < 4; j++) send_byte(8'(prog[i] >> (8 * j)), duty);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_run();
        for (int i = 0; i < 6 && core_rst; i++) @(negedge clk);
        #1;
        check("core_released", core_rst, 0);
    endtask

    task automatic check_load(input int n);
        check("we_count", we_cnt, n);
        check("we_pending", exp_q.size(), 0);
        if (n > 0) check("release_latency", fall_cyc - last_we_cyc, 1);
        check("in_ready_run", in_ready, 0);
        check("busy_run", busy, 1);
    endtask

    // Outcome model: halt at count h (0..MAXC) ends in DONE holding h, else timeout at MAXC.
    task automatic run_phase(input int halt_at);
        int k        = 0;
        bit exp_done = (halt_at >= 0) && (halt_at <= MAXC);
        int exp_cnt  = exp_done ? halt_at : MAXC;
        check("run_count_start", cycle_count, 0);
        while (1) begin
            if (k == halt_at || k == MAXC) begin
                halt = (k == halt_at);
                @(negedge clk);
                #1;
                halt = 1'b0;
                break;
            end
            @(negedge clk);
            #1;
            k++;
            if (k == 5) check("run_count_mid", cycle_count, 5);
        end
        check("run_done", done, exp_done);
        check("run_error", error, !exp_done);
        check("run_count_final", cycle_count, exp_cnt);
        check("run_core_rst", core_rst, 1);
        check("run_busy", busy, 0);
        check("run_in_ready", in_ready, 0);
        repeat (3) @(negedge clk);
        check("run_count_held", cycle_count, exp_cnt);
        check("run_done_sticky", done, exp_done);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_imem_we"}, imem_we, 0);
        check({tag, "_imem_addr"}, imem_addr, 0);
        check({tag, "_imem_wdata"}, imem_wdata, 0);
        check({tag, "_core_rst"}, core_rst, 1);
        check({tag, "_flags"}, {busy, done, error}, 0);
        check({tag, "_cycle_count"}, cycle_count, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #3 rst = 1'b0;
        #1 check_reset_state("por");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        halt = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_halt_ignored", {core_rst, busy, done, error}, 4'b1000);
        halt = 1'b0;

        // Known two-word program
        prog[0] = 32'h00100513;
        prog[1] = 32'h00200593;
        pulse_start();
        load(2, 100);
        wait_run();
        check_load(2);
        check("t1_mem0", mem_obs[0], 32'h00100513);
        check("t1_mem1", mem_obs[1], 32'h00200593);
        run_phase(10);

        // Oversize header
        pulse_start();
        stalled = 1'b0;
        exp_q.delete();
        we_cnt = 0;
        send_byte(8'h01, 100);
        send_byte(8'h01, 100);
        @(negedge clk);
        in_valid = 1'b0;
        check("ovr_error", error, 1);
        check("ovr_in_ready", in_ready, 0);
        repeat (3) @(negedge clk);
        check("ovr_no_we", we_cnt, 0);
        check("ovr_core_rst", core_rst, 1);
        check("ovr_busy", busy, 0);

        // Full capacity load
        for (int i = 0; i < 256; i++) prog[i] = $urandom;
        pulse_start();
        load(256, 100);
        wait_run();
        check_load(256);
        run_phase(3);

        // Empty program goes straight to RUN
        pulse_start();
        load(0, 100);
        wait_run();
        check_load(0);
        run_phase(int'($urandom_range(MAXC + 5)));

        // 16 words with sparse valid, then same words back-to-back
        for (int i = 0; i < 16; i++) prog[i] = $urandom;
        pulse_start();
        load(16, 30);
        wait_run();
        check_load(16);
        run_phase(-1);
        pulse_start();
        load(16, 100);
        wait_run();
        check_load(16);
        run_phase(MAXC);

        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(24, 1));
            for (int i = 0; i < n; i++) prog[i] = $urandom;
            pulse_start();
            load(n, int'($urandom_range(100, 20)));
            wait_run();
            check_load(n);
            run_phase(int'($urandom_range(MAXC + 5)));
        end

        // Reset during the third word of an eight-word load
        for (int i = 0; i < 8; i++) prog[i] = $urandom;
        pulse_start();
        stalled = 1'b0;
        exp_q.delete();
        we_cnt = 0;
        for (int i = 0; i < 8; i++) exp_q.push_back({8'(i), prog[i]});
        send_byte(8'd8, 100);
        send_byte(8'd0, 100);
        for (int i = 0; i < 10; i++) send_byte(8'(prog[i / 4] >> (8 * (i % 4))), 100);
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_busy", busy, 1);
        #2 rst = 1'b0;
        #1 check_reset_state("mid");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        pulse_start();
        load(8, 100);
        wait_run();
        check_load(8);
        run_phase(7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
